f1_start_sequencer: RTL and testbench

Parametrised starting-light sequencer and reaction timer. Lights NUM_LIGHTS lamps one per STEP_MS, holds all lamps for a pseudo-random delay, then extinguishes them and measures the driver's reaction in milliseconds. Adds jump-start detection, timeout and a registered result handshake. Sits between the 1 kHz tick generator and the binary-to-BCD/seven-segment display path, replacing the fixed-width FSM + delay + LFSR trio.

---
 rtl/f1_start_sequencer_if.sv | 27 ++
 rtl/f1_start_sequencer.sv | 155 +++++++++++++++
 tb/tb_f1_start_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/f1_start_sequencer_if.sv
// Signal bundle between the tick/input front end and the start sequencer.
// Result handshake: result_valid is high while results are stable; there is no ready, and results hold until the next trigger edge.
interface f1_start_sequencer_if #(
  parameter int NUM_LIGHTS = 10,
  parameter int RW         = 14
);
  logic                  tick_ms;
  logic                  trigger;
  logic                  react;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  busy;
  logic                  result_valid;
  logic [RW-1:0]         react_ms;
  logic                  jump_start;
  logic                  timeout;
  logic [2:0]            dbg_state;

  modport master (
    output tick_ms, trigger, react,
    input  lights, busy, result_valid, react_ms, jump_start, timeout, dbg_state
  );

  modport slave (
    input  tick_ms, trigger, react,
    output lights, busy, result_valid, react_ms, jump_start, timeout, dbg_state
  );
endinterface

// File: rtl/f1_start_sequencer.sv
// Starting-light sequencer and reaction timer: lamps on one per step, random hold,
// lamps out, then millisecond reaction count with jump-start and timeout detection.
module f1_start_sequencer #(
  parameter int                    NUM_LIGHTS    = 10,
  parameter int                    STEP_MS       = 500,
  parameter int                    LFSR_WIDTH    = 7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 7'b1100000,
  parameter int                    MIN_DELAY_MS  = 200,
  parameter int                    DELAY_UNIT_MS = 25,
  parameter int                    MAX_REACT_MS  = 9999
) (
  input logic                  clk,
  input logic                  rst_n,
  f1_start_sequencer_if.slave  bus
);
  localparam int RW       = $clog2(MAX_REACT_MS + 1);
  localparam int HOLD_MAX = MIN_DELAY_MS + ((2 ** LFSR_WIDTH) - 1) * DELAY_UNIT_MS;
  localparam int CNT_MAX  = (HOLD_MAX > STEP_MS) ? HOLD_MAX : STEP_MS;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]         STEP_LAST = CW'(STEP_MS - 1);
  localparam logic [RW-1:0]         REACT_MAX = RW'(MAX_REACT_MS);
  localparam logic [NUM_LIGHTS-1:0] ALL_ON    = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LIGHTS = 3'd1,
    S_HOLD   = 3'd2,
    S_TIMING = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           hold_q, hold_d;
  logic [RW-1:0]           react_q, react_d;
  logic                    jump_q, jump_d;
  logic                    to_q, to_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    trig_prev_q, react_prev_q;
  logic                    trig_edge, react_edge;

  assign trig_edge  = bus.trigger & ~trig_prev_q;
  assign react_edge = bus.react & ~react_prev_q;

  // Free-running so the snapshot depends on when the driver pressed trigger.
  assign lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    react_d  = react_q;
    jump_d   = jump_q;
    to_d     = to_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (trig_edge) begin
          state_d  = S_LIGHTS;
          lights_d = '0;
          cnt_d    = '0;
          react_d  = '0;
          jump_d   = 1'b0;
          to_d     = 1'b0;
        end
      end
      S_LIGHTS, S_HOLD: begin
        if (react_edge) begin
          state_d  = S_DONE;
          lights_d = ALL_ON;
          react_d  = '0;
          jump_d   = 1'b1;
        end else if (bus.tick_ms) begin
          if (state_q == S_LIGHTS) begin
            if (cnt_q == STEP_LAST) begin
              cnt_d    = '0;
              lights_d = {lights_q[NUM_LIGHTS-2:0], 1'b1};
              if (&lights_q[NUM_LIGHTS-2:0]) begin
                hold_d  = CW'(MIN_DELAY_MS) + CW'(lfsr_q) * CW'(DELAY_UNIT_MS);
                state_d = S_HOLD;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (cnt_q == hold_q - CW'(1)) begin
            cnt_d    = '0;
            lights_d = '0;
            state_d  = S_TIMING;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_TIMING: begin
        // A press in the same cycle as a tick keeps the pre-tick count.
        if (react_edge) begin
          state_d = S_DONE;
        end else if (bus.tick_ms) begin
          if (react_q == REACT_MAX - RW'(1)) begin
            react_d = REACT_MAX;
            to_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            react_d = react_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_LIGHTS) || (state_d == S_HOLD) || (state_d == S_TIMING);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lights_q     <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      react_q      <= '0;
      jump_q       <= 1'b0;
      to_q         <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      lfsr_q       <= LFSR_WIDTH'(1);
      trig_prev_q  <= 1'b0;
      react_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lights_q     <= lights_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      react_q      <= react_d;
      jump_q       <= jump_d;
      to_q         <= to_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      lfsr_q       <= lfsr_d;
      trig_prev_q  <= bus.trigger;
      react_prev_q <= bus.react;
    end
  end

  assign bus.lights       = lights_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.react_ms     = react_q;
  assign bus.jump_start   = jump_q;
  assign bus.timeout      = to_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_f1_start_sequencer.sv
// Bench for f1_start_sequencer: directed scenarios plus randomized runs, every cycle
// compared against a tick-count reference model of the start procedure.
module tb_f1_start_sequencer;
  localparam int N     = 4;
  localparam int STEP  = 3;
  localparam int W     = 7;
  localparam int MIN   = 2;
  localparam int UNIT  = 1;
  localparam int MAXR  = 20;
  localparam int RW    = 5;
  localparam int L     = N * STEP;
  localparam logic [W-1:0] TAPS = 7'b1100000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  f1_start_sequencer_if #(.NUM_LIGHTS(N), .RW(RW)) bus ();

  f1_start_sequencer #(
    .NUM_LIGHTS(N), .STEP_MS(STEP), .LFSR_WIDTH(W), .LFSR_TAPS(TAPS),
    .MIN_DELAY_MS(MIN), .DELAY_UNIT_MS(UNIT), .MAX_REACT_MS(MAXR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: everything derives from the tick count n since the run began.
  logic [W-1:0] lfsr_m;
  logic         tp_m, rp_m;
  bit           m_active, m_jump, m_to, m_valid;
  int           m_n, m_hold, m_react;
  logic [N-1:0] m_lights;

  function automatic logic [W-1:0] adv(input logic [W-1:0] x, input int k);
    logic [W-1:0] v;
    v = x;
    for (int i = 0; i < k; i++) v = {v[W-2:0], ^(v & TAPS)};
    return v;
  endfunction

  function automatic logic [N-1:0] ones(input int k);
    return N'((1 << k) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    m_active = 1'b0;
    m_valid  = 1'b1;
  endtask

  task automatic model_edge(input bit t, input bit tr, input bit re, input bit rn);
    bit           te, rge;
    logic [W-1:0] pre;
    te   = tr & ~tp_m;
    rge  = re & ~rp_m;
    tp_m = rn ? tr : 1'b0;
    rp_m = rn ? re : 1'b0;
    pre  = lfsr_m;
    lfsr_m = rn ? adv(lfsr_m, 1) : W'(1);
    if (!rn) begin
      m_active = 0; m_lights = '0; m_react = 0; m_jump = 0; m_to = 0; m_valid = 0;
    end else if (!m_active) begin
      if (te) begin
        m_active = 1; m_n = 0; m_hold = 0; m_lights = '0;
        m_react = 0; m_jump = 0; m_to = 0; m_valid = 0;
      end
    end else if (rge) begin
      if (m_n < L || m_n < L + m_hold) begin
        m_jump = 1; m_lights = '1; m_react = 0;
      end else begin
        m_react = m_n - L - m_hold;
      end
      finish_run();
    end else if (t) begin
      m_n++;
      if (m_n == L) m_hold = MIN + int'(pre) * UNIT;
      if (m_n < L) m_lights = ones(m_n / STEP);
      else if (m_n < L + m_hold) m_lights = '1;
      else begin
        m_lights = '0;
        m_react  = m_n - L - m_hold;
        if (m_react >= MAXR) begin
          m_react = MAXR; m_to = 1; finish_run();
        end
      end
    end
  endtask

  // One clock cycle: drive, clock, update the model, compare every output.
  task automatic cyc(input bit t, input bit tr, input bit re, input bit rn);
    bus.tick_ms = t;
    bus.trigger = tr;
    bus.react   = re;
    rst_n       = rn;
    @(posedge clk);
    model_edge(t, tr, re, rn);
    #1;
    chk("lights", 32'(bus.lights), 32'(m_lights));
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("result_valid", 32'(bus.result_valid), 32'(m_valid));
    chk("react_ms", 32'(bus.react_ms), 32'(m_react));
    chk("jump_start", 32'(bus.jump_start), 32'(m_jump));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic tick_until(input int target);
    for (int i = 0; i < 600 && m_active && m_n < target; i++) cyc(1, 0, 0, 1);
  endtask

  initial begin
    lfsr_m = W'(1); tp_m = 0; rp_m = 0;
    m_active = 0; m_jump = 0; m_to = 0; m_valid = 0;
    m_n = 0; m_hold = 0; m_react = 0; m_lights = '0;

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_lights", 32'(bus.lights), 0);
    chk("rst_valid", 32'(bus.result_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // React in IDLE is ignored
    cyc(0, 0, 1, 1);
    chk("idle_react_busy", 32'(bus.busy), 0);
    chk("idle_react_jump", 32'(bus.jump_start), 0);
    cyc(0, 0, 0, 1);

    // Time the trigger so the snapshot taken at the all-on edge is 5 (hold = 7 ticks)
    for (int i = 0; i < 300 && adv(lfsr_m, L) != W'(5); i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_lights", 32'(bus.lights), 0);
    for (int k = 1; k <= L; k++) begin
      cyc(1, 0, 0, 1);
      if (k % STEP == 0) chk("lamp_step", 32'(bus.lights), 32'((1 << (k / STEP)) - 1));
      if (k == STEP - 1) chk("lamp_early", 32'(bus.lights), 0);
    end
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0, 0, 1);
      if (i == 6) chk("hold6_lights", 32'(bus.lights), 32'hF);
      if (i == 7) chk("hold7_lights", 32'(bus.lights), 0);
    end
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("react12_ms", 32'(bus.react_ms), 12);
    chk("react12_valid", 32'(bus.result_valid), 1);
    chk("react12_jump", 32'(bus.jump_start), 0);
    chk("react12_to", 32'(bus.timeout), 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    chk("done_react_ms", 32'(bus.react_ms), 12);
    cyc(0, 0, 0, 1);

    // Timeout run
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 600 && m_active; i++) cyc(1, 0, 0, 1);
    chk("to_ms", 32'(bus.react_ms), MAXR);
    chk("to_flag", 32'(bus.timeout), 1);
    chk("to_lights", 32'(bus.lights), 0);
    chk("to_valid", 32'(bus.result_valid), 1);

    // Trigger and react together in DONE: new run, react ignored
    cyc(0, 1, 1, 1);
    chk("tr_wins_busy", 32'(bus.busy), 1);
    chk("tr_wins_jump", 32'(bus.jump_start), 0);
    chk("tr_wins_ms", 32'(bus.react_ms), 0);
    cyc(0, 0, 0, 1);

    // Jump start during HOLD
    tick_until(L + 1);
    cyc(0, 0, 1, 1);
    chk("jump_flag", 32'(bus.jump_start), 1);
    chk("jump_lights", 32'(bus.lights), 32'hF);
    chk("jump_ms", 32'(bus.react_ms), 0);
    chk("jump_valid", 32'(bus.result_valid), 1);
    cyc(0, 0, 0, 1);

    // Trigger ignored in TIMING; react with simultaneous tick keeps count 5
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 600 && m_active && (m_n < L || m_n < L + m_hold); i++) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    chk("timing_trig_busy", 32'(bus.busy), 1);
    chk("timing_trig_ms", 32'(bus.react_ms), 4);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1);
    chk("tie_ms", 32'(bus.react_ms), 5);
    chk("tie_valid", 32'(bus.result_valid), 1);
    cyc(0, 0, 0, 1);

    // Reset during HOLD aborts; a fresh trigger starts from zero lamps
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    tick_until(L + 1);
    cyc(0, 0, 0, 0);
    chk("abort_lights", 32'(bus.lights), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_valid", 32'(bus.result_valid), 0);
    cyc(0, 1, 0, 1);
    chk("restart_lights", 32'(bus.lights), 0);
    chk("restart_busy", 32'(bus.busy), 1);
    for (int i = 0; i < STEP; i++) cyc(1, 0, 0, 1);
    chk("restart_lamp1", 32'(bus.lights), 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    // Randomized runs: irregular ticks, random press time, trigger noise
    for (int r = 0; r < 14; r++) begin
      int  target;
      bit  pressed;
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      target  = $urandom_range(0, L + 40);
      pressed = 0;
      for (int i = 0; i < 2000 && m_active; i++) begin
        bit t, tr, re;
        t  = ($urandom_range(0, 1) == 0);
        tr = ($urandom_range(0, 7) == 0);
        re = (!pressed && m_n >= target);
        if (re) pressed = 1;
        cyc(t, tr, re, 1);
      end
      chk("rand_done_valid", 32'(bus.result_valid), 1);
      for (int i = 0; i < 3; i++) cyc($urandom_range(0, 1), 0, $urandom_range(0, 1), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
